// File: rtl/axi_sram_bridge.sv
// AXI3 slave bridging single-burst read/write traffic onto a single-port synchronous SRAM.
// Optional: define AXI_SRAM_WRAP_EN to honour WRAP bursts; otherwise WRAP behaves as INCR.
module axi_sram_bridge #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned SRAM_AW   = $clog2(MEM_BYTES) - 2,
    parameter logic [31:0] BASE_ADDR = 32'h1fc00000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         arid,
    input  logic [31:0]        araddr,
    input  logic [3:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    input  logic               arvalid,
    output logic               arready,
    output logic [3:0]         rid,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready,
    input  logic [3:0]         awid,
    input  logic [31:0]        awaddr,
    input  logic [3:0]         awlen,
    input  logic [2:0]         awsize,
    input  logic [1:0]         awburst,
    input  logic               awvalid,
    output logic               awready,
    input  logic [3:0]         wid,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    output logic [3:0]         bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    output logic               sram_en,
    output logic [3:0]         sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    localparam int OW = SRAM_AW + 2;
    localparam logic [OW-1:0] ONE_OFF = {{(OW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    id_q, len_q, beat_q;
    logic [OW-1:0] off_q, off_nxt, incr;
    logic [1:0]    size_q, burst_q, count_q;
    logic          decerr_q, slverr_q, prefer_wr_q, issued_all_q;
    logic          inflight_q, infl_last_q, wr_ptr_q, rd_ptr_q;
    logic [31:0]   buf_data_q [2];
    logic          buf_last_q [2];

    logic          grant_rd, grant_wr, beat_last, rvalid_int, rd_issue, w_beat;
    logic          r_pop, buf_pop, buf_push, head_last;
    logic [31:0]   start_full, rd_word, head_data;
    logic          unused_wid;

    assign unused_wid = ^wid;

    function automatic logic [1:0] size_eff(input logic [2:0] s);
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    always_comb begin
        grant_rd   = arvalid && (!awvalid || !prefer_wr_q);
        grant_wr   = awvalid && !grant_rd;
        start_full = (grant_wr ? awaddr : araddr) - BASE_ADDR;
        beat_last  = (beat_q == len_q);
        rvalid_int = (state_q == RD) && ((count_q != 2'd0) || inflight_q);
        // Credit: buffered beats plus the read in flight may never exceed the two-entry buffer.
        rd_issue   = (state_q == RD) && !issued_all_q &&
                     (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
        w_beat     = (state_q == WR) && wvalid;
        rd_word    = decerr_q ? 32'h0 : sram_rdata;
        head_data  = (count_q != 2'd0) ? buf_data_q[rd_ptr_q] : rd_word;
        head_last  = (count_q != 2'd0) ? buf_last_q[rd_ptr_q] : infl_last_q;
        r_pop      = rvalid_int && rready;
        buf_pop    = (count_q != 2'd0) && rready;
        buf_push   = inflight_q && !((count_q == 2'd0) && rready);
    end

    always_comb begin
        incr    = ONE_OFF << size_q;
        off_nxt = (burst_q == 2'b00) ? off_q : off_q + incr;
`ifdef AXI_SRAM_WRAP_EN
        if (burst_q == 2'b10 && (len_q == 4'd1 || len_q == 4'd3 || len_q == 4'd7 || len_q == 4'd15)) begin
            off_nxt = (off_q & ~((({{(OW-4){1'b0}}, len_q} + ONE_OFF) << size_q) - ONE_OFF)) |
                      ((off_q + incr) & ((({{(OW-4){1'b0}}, len_q} + ONE_OFF) << size_q) - ONE_OFF));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_rd) state_d = RD; else if (grant_wr) state_d = WR;
            RD:      if (r_pop && head_last) state_d = IDLE;
            WR:      if (w_beat && beat_last) state_d = WRESP;
            WRESP:   if (bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bid        = 4'h0;
        bresp      = 2'b00;
        rvalid     = 1'b0;
        rid        = 4'h0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_wdata = 32'h0;
        sram_addr  = off_q[OW-1:2];
        case (state_q)
            IDLE: begin
                arready = grant_rd;
                awready = grant_wr;
            end
            RD: begin
                rvalid  = rvalid_int;
                sram_en = rd_issue && !decerr_q;
                if (rvalid_int) begin
                    rid   = id_q;
                    rdata = head_data;
                    rresp = decerr_q ? 2'b11 : 2'b00;
                    rlast = head_last;
                end
            end
            WR: begin
                wready = 1'b1;
                if (w_beat && !decerr_q) begin
                    sram_en    = 1'b1;
                    sram_we    = wstrb;
                    sram_wdata = wdata;
                end
            end
            WRESP: begin
                bvalid = 1'b1;
                bid    = id_q;
                bresp  = decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_wr_q  <= 1'b0;
            issued_all_q <= 1'b0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && (grant_rd || grant_wr)) begin
                prefer_wr_q  <= grant_rd;
                issued_all_q <= 1'b0;
            end else if (rd_issue && beat_last) begin
                issued_all_q <= 1'b1;
            end
            inflight_q <= rd_issue;
            if (buf_push) wr_ptr_q <= !wr_ptr_q;
            if (buf_pop)  rd_ptr_q <= !rd_ptr_q;
            count_q <= count_q + 2'(buf_push) - 2'(buf_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && (grant_rd || grant_wr)) begin
            id_q     <= grant_wr ? awid : arid;
            off_q    <= start_full[OW-1:0];
            len_q    <= grant_wr ? awlen : arlen;
            size_q   <= size_eff(grant_wr ? awsize : arsize);
            burst_q  <= grant_wr ? awburst : arburst;
            beat_q   <= 4'd0;
            decerr_q <= (start_full[31:OW] != '0);
            slverr_q <= 1'b0;
        end else if (rd_issue || w_beat) begin
            off_q  <= off_nxt;
            beat_q <= beat_q + 4'd1;
        end
        if (w_beat && (wlast != beat_last)) slverr_q <= 1'b1;
        infl_last_q <= beat_last;
        if (buf_push) begin
            buf_data_q[wr_ptr_q] <= rd_word;
            buf_last_q[wr_ptr_q] <= infl_last_q;
        end
    end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed self-checking bench for axi_sram_bridge with a behavioural SRAM model.
module tb_axi_sram_bridge;

    localparam int          MEM_BYTES = 65536;
    localparam int          SRAM_AW   = 14;
    localparam logic [31:0] BASE      = 32'h1fc00000;

    logic clk, reset;
    logic [3:0] arid, arlen, awid, awlen, wid, wstrb, rid, bid, sram_we;
    logic [31:0] araddr, awaddr, wdata, rdata, sram_wdata, sram_rdata;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic wlast, wvalid, wready, bvalid, bready, sram_en;
    logic [SRAM_AW-1:0] sram_addr;

    axi_sram_bridge #(.MEM_BYTES(MEM_BYTES), .SRAM_AW(SRAM_AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SRAM model with a bench-side preload port
    logic [31:0] mem [0:(1<<SRAM_AW)-1];
    logic        pl_en = 1'b0;
    logic [SRAM_AW-1:0] pl_addr;
    logic [31:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (sram_en) begin
            if (sram_we == 4'h0) sram_rdata <= mem[sram_addr];
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rq_data[$];
    logic        rq_last[$];
    logic [1:0]  rq_resp[$];
    logic [3:0]  rq_id[$];
    int          rq_cyc[$];
    int rd_strobes = 0, rbeats = 0, max_out = 0, first_rd_cyc = -1, en_cnt = 0;
    bit r_stall = 0, b_stall = 0;
    logic [31:0] r_prev;
    logic        r_prev_last;
    logic [3:0]  b_prev_id;

    always @(negedge clk) begin
        if (!reset) begin
            if (r_stall) begin
                check_val("r_hold_valid", rvalid, 1);
                check_val("r_hold_data", rdata, r_prev);
                check_val("r_hold_last", rlast, r_prev_last);
            end
            if (b_stall) begin
                check_val("b_hold_valid", bvalid, 1);
                check_val("b_hold_id", bid, b_prev_id);
            end
        end
        r_stall = rvalid && !rready;
        r_prev = rdata;
        r_prev_last = rlast;
        b_stall = bvalid && !bready;
        b_prev_id = bid;
        if (sram_en && sram_we == 4'h0) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc + 1;
            rd_strobes++;
        end
        if (sram_en) en_cnt++;
        if (rvalid && rready) begin
            rq_data.push_back(rdata);
            rq_last.push_back(rlast);
            rq_resp.push_back(rresp);
            rq_id.push_back(rid);
            rq_cyc.push_back(cyc + 1);
            rbeats++;
        end
        if (rd_strobes - rbeats > max_out) max_out = rd_strobes - rbeats;
    end

    task automatic clear_mon();
        rq_data.delete(); rq_last.delete(); rq_resp.delete(); rq_id.delete(); rq_cyc.delete();
        rd_strobes = 0; rbeats = 0; max_out = 0; first_rd_cyc = -1; en_cnt = 0;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_addr = idx[SRAM_AW-1:0];
        pl_data = val;
        pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input logic [1:0] burst, input bit toggle, output int t_hs);
        clear_mon();
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst;
        arvalid = 1'b1; rready = 1'b1; t_hs = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (arready) begin t_hs = cyc + 1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        check_val("ar_hs", (t_hs >= 0), 1);
        for (int c = 0; c < 40; c++) begin
            if (rq_data.size() >= int'(len) + 1) break;
            @(posedge clk); #1;
            if (toggle) rready = !rready;
        end
        rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("r_beats", rq_data.size(), int'(len) + 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [3:0] s0, input logic [3:0] s1, input bit bad_last,
                            output logic [1:0] resp, output logic [3:0] id_o);
        bit ok;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        resp = 2'b01; id_o = 4'h0; ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        check_val("aw_hs", ok, 1);
        for (int b = 0; b <= int'(len); b++) begin
            wid = id;
            wdata = (b == 0) ? d0 : d1;
            wstrb = (b == 0) ? s0 : s1;
            wlast = (b == int'(len)) ^ bad_last;
            wvalid = 1'b1; ok = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (wready) begin ok = 1; break; end
            end
            @(posedge clk); #1;
            check_val("w_hs", ok, 1);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bvalid) begin resp = bresp; id_o = bid; ok = 1; break; end
        end
        @(posedge clk); #1;
        bready = 1'b0;
        check_val("b_hs", ok, 1);
    endtask

    int          t;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_id;
    int          grants[3];
    int          ng, nb, bwait, bwait_max;
    logic [31:0] exp6 [4];

    initial begin
        reset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 1;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_arready", arready, 0);
        check_val("rst_awready", awready, 0);
        check_val("rst_wready", wready, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_bvalid", bvalid, 0);
        check_val("rst_sram_en", sram_en, 0);
        check_val("rst_sram_we", sram_we, 0);
        check_val("rst_rid_bid", {rid, bid}, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_resp_last", {rresp, bresp, rlast}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) preload(i, 32'h100 + i);

        // INCR read, rready held high
        do_read(BASE + 32'h10, 4'd3, 4'd5, 2'b01, 1'b0, t);
        check_val("t1_first_rd", first_rd_cyc, t + 1);
        for (int k = 0; k < 4; k++) begin
            check_val("t1_data", rq_data[k], 32'h104 + k);
            check_val("t1_last", rq_last[k], (k == 3));
            check_val("t1_id", rq_id[k], 5);
            check_val("t1_resp", rq_resp[k], 0);
            check_val("t1_cyc", rq_cyc[k], t + 2 + k);
        end

        // Same read with toggling rready
        do_read(BASE + 32'h10, 4'd3, 4'd5, 2'b01, 1'b1, t);
        for (int k = 0; k < 4; k++) begin
            check_val("t2_data", rq_data[k], 32'h104 + k);
            check_val("t2_last", rq_last[k], (k == 3));
        end
        check_val("t2_max_out", (max_out <= 2), 1);

        // INCR write with partial strobe on second beat
        preload(1, 32'hCAFE0101);
        do_write(BASE, 4'd1, 4'd9, 32'hAABBCCDD, 32'h11223344, 4'hF, 4'h3, 1'b0, wr_resp, wr_id);
        check_val("t3_bid", wr_id, 9);
        check_val("t3_bresp", wr_resp, 0);
        check_val("t3_word0", mem[0], 32'hAABBCCDD);
        check_val("t3_word1", mem[1], 32'hCAFE3344);

        // wlast disagreeing with awlen
        do_write(BASE + 32'h40, 4'd1, 4'd2, 32'h01020304, 32'h05060708, 4'hF, 4'hF, 1'b1, wr_resp, wr_id);
        check_val("t3_slverr", wr_resp, 2'b10);
        check_val("t3_slv_word", mem[17], 32'h05060708);

        // Out-of-range write
        clear_mon();
        do_write(BASE + MEM_BYTES, 4'd0, 4'd3, 32'h12345678, 32'h0, 4'hF, 4'h0, 1'b0, wr_resp, wr_id);
        check_val("t3_decerr", wr_resp, 2'b11);
        check_val("t3_dec_bid", wr_id, 3);
        check_val("t3_dec_no_en", en_cnt, 0);

        // Out-of-range read
        do_read(BASE + MEM_BYTES, 4'd2, 4'd4, 2'b01, 1'b0, t);
        for (int k = 0; k < 3; k++) begin
            check_val("t5_resp", rq_resp[k], 2'b11);
            check_val("t5_data", rq_data[k], 0);
            check_val("t5_last", rq_last[k], (k == 2));
        end
        check_val("t5_no_en", en_cnt, 0);

        // Simultaneous AR/AW from reset: grants must alternate starting with read
        clear_mon();
        reset = 1'b1;
        arid = 4'd1; araddr = BASE; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd7; awaddr = BASE + 32'h80; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        wid = 4'd7; wdata = 32'h5A5A0000; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        bready = 1'b0; rready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ng = 0; nb = 0; bwait = 0; bwait_max = 0;
        for (int i = 0; i < 3; i++) grants[i] = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (arvalid && arready && ng < 3) begin grants[ng] = 0; ng++; end
            if (awvalid && awready && ng < 3) begin grants[ng] = 1; ng++; end
            if (bvalid && !bready) begin
                bwait++;
                if (bwait > bwait_max) bwait_max = bwait;
            end
            if (bvalid && bready) begin
                nb++;
                check_val("t4_bid", bid, 7);
                check_val("t4_bresp", bresp, 0);
                bwait = 0;
            end
            @(posedge clk); #1;
            if (ng == 3) begin arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; end
            bready = (bwait >= 2);
        end
        wlast = 1'b0; bready = 1'b0;
        check_val("t4_grant0", grants[0], 0);
        check_val("t4_grant1", grants[1], 1);
        check_val("t4_grant2", grants[2], 0);
        check_val("t4_nb", nb, 1);
        check_val("t4_bwait", bwait_max, 2);
        check_val("t4_rbeats", rq_data.size(), 2);
        check_val("t4_rdata", rq_data[0], 32'hAABBCCDD);

        // WRAP burst crossing the 16-byte window
`ifdef AXI_SRAM_WRAP_EN
        exp6[0] = 32'h106; exp6[1] = 32'h107; exp6[2] = 32'h104; exp6[3] = 32'h105;
`else
        exp6[0] = 32'h106; exp6[1] = 32'h107; exp6[2] = 32'h108; exp6[3] = 32'h109;
`endif
        do_read(BASE + 32'h18, 4'd3, 4'd6, 2'b10, 1'b0, t);
        for (int k = 0; k < 4; k++) check_val("t6_data", rq_data[k], exp6[k]);
        check_val("t6_last", rq_last[3], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
